ysyx_23060240_axi_rd_arbiter: RTL
=================================

// Module: ysyx_23060240_axi_rd_arbiter
// PURPOSE
//   Shares one AXI4-Lite read-only slave port (instruction/data SRAM) between
//   two masters: M0 = IFU instruction fetch, M1 = LSU load path.
//   Grants round-robin on simultaneous requests and keeps exactly one
//   transaction (AR then R) outstanding at a time.
//   Sits between IFU/LSU and the shared SRAM model.
// PARAMETERS
//   AW         32  address width
//   DW         32  data width
//   FIRST_PRIO 0   master favoured at first contention after reset (0=IFU,1=LSU)
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active-high
//   m0_araddr     in   AW  IFU read address
//   m0_arvalid    in   1   IFU address valid
//   m0_arready    out  1   IFU address accepted
//   m0_rvalid     out  1   IFU read data valid
//   m0_rready     in   1   IFU ready for data
//   m0_rdata      out  DW  IFU read data
//   m0_rresp      out  2   IFU read response
//   m1_araddr     in   AW  LSU read address
//   m1_arvalid    in   1   LSU address valid
//   m1_arready    out  1   LSU address accepted
//   m1_rvalid     out  1   LSU read data valid
//   m1_rready     in   1   LSU ready for data
//   m1_rdata      out  DW  LSU read data
//   m1_rresp      out  2   LSU read response
//   s_araddr      out  AW  slave read address
//   s_arvalid     out  1   slave address valid
//   s_arready     in   1   slave address accepted
//   s_rvalid      in   1   slave data valid
//   s_rready      out  1   ready for slave data
//   s_rdata       in   DW  slave read data
//   s_rresp       in   2   slave read response
//   busy          out  1   transaction in flight (state != IDLE)
// BEHAVIOUR
//   - States: IDLE -> ADDR -> DATA -> IDLE; state, grant, last_grant are regs.
//   - Reset: async; state=IDLE, grant=0, last_grant=~FIRST_PRIO. All valid/
//     ready outputs, busy = 0; s_araddr = 0.
//   - IDLE: no handshake outputs asserted. Arbitration:
//     one arvalid -> grant that master; both -> grant ~last_grant.
//     Next cycle: ADDR, last_grant<=grant. Arbitration latency = 1 cycle.
//   - ADDR: s_araddr = mN_araddr, s_arvalid = mN_arvalid, mN_arready =
//     s_arready (N = grant). Loser's arready = 0. On s_arvalid&s_arready -> DATA.
//     Masters hold arvalid until arready (AXI rule).
//   - DATA: mN_rvalid = s_rvalid, s_rready = mN_rready, mN_rdata/rresp =
//     s_rdata/s_rresp. Loser's rvalid = 0; its rdata/rresp = 0.
//     On s_rvalid&s_rready -> IDLE.
//   - Path timing: ADDR/DATA forwarding is combinational; no data buffering.
//     Minimum transaction: 3 cycles (IDLE, ADDR, DATA) plus slave latency.
//   - Loser request: held pending. It wins the next IDLE arbitration
//     (round-robin), so no master starves.
//   - Slave stalls: no timeout. Arbiter waits indefinitely in ADDR or DATA.
//   - New arvalid during ADDR/DATA: ignored until IDLE.
//   - Reset mid-transaction: immediate return to IDLE, outputs deasserted.
//     Any slave response after reset is dropped (s_rready=0).
//   - busy = (state != IDLE).
// TESTING
//   1. IFU alone reads 0x8000_0000; slave arready at cycle 1, rvalid at
//      cycle 2, rdata=0x0000_0413 -> m0 gets rdata 0x413 rresp 0;
//      m1 outputs stay 0.
//   2. Both arvalid same cycle after reset, FIRST_PRIO=0 -> IFU served first,
//      then LSU. Repeat -> next contention grants IFU again (alternation).
//   3. LSU alone, slave delays arready 3 cycles and rvalid 4 cycles ->
//      s_arvalid held high 3 cycles, m1_arready one pulse, then m1_rvalid
//      one pulse; busy high throughout.
//   4. Master delays rready 2 cycles after s_rvalid -> state stays DATA;
//      s_rready follows m_rready; exactly one R handshake.
//   5. rst asserted in DATA with s_rvalid low -> same edge: busy=0,
//      all arready/rvalid/s_rready=0. Later slave rvalid is not forwarded.
//   6. IFU arvalid held continuously, LSU request arrives in ADDR ->
//      LSU waits; next IDLE grants LSU before IFU's following fetch.

Source files
------------

// File: rtl/ysyx_23060240_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read slave between IFU (m0) and LSU (m1).
// Exactly one AR/R transaction is in flight; address and data paths are forwarded combinationally.
module ysyx_23060240_axi_rd_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    input  logic [AW-1:0] m1_araddr,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic [AW-1:0] s_araddr,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic          s_rvalid,
    output logic          s_rready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= ~FIRST_PRIO;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On contention the master that did not win last time is served.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    if (m0_arvalid && m1_arvalid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = m1_arvalid;
                    end
                    last_grant_d = grant_d;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (s_arvalid && s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        unique case (state_q)
            ADDR: begin
                if (grant_q) begin
                    s_araddr   = m1_araddr;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
            end
            DATA: begin
                if (grant_q) begin
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
